// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM state encoding,
// default buffer/burst sizes and the fixed refill counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REFILL
  } arb_state_t;

  localparam int unsigned BURST_LEN_DEF  = 16;
  localparam int unsigned WBUF_DEPTH_DEF = 4;
  localparam int unsigned CNT_W          = 5;

endpackage

// File: rtl/write_buffer_fifo.sv
// Write-through buffer: an in-order address/data FIFO that also reports whether
// any occupied entry falls inside the 16-word block named by match_tag.
module write_buffer_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned DEPTH      = WBUF_DEPTH_DEF,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  input  logic [ADDR_WIDTH-5:0] match_tag,
  output logic                  match_hit
);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      slot;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  // A push while full is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; count/pointers alone say
  // which slots hold live data, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: outputs of always_comb get a default before any branch so no latch is inferred.
  always_comb begin
    match_hit = 1'b0;
    slot      = rd_ptr;
    for (int i = 0; i < int'(DEPTH); i++) begin
      slot = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (addr_mem[slot][ADDR_WIDTH-1:4] == match_tag))
        match_hit = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one main-memory port between buffered write-through traffic and
// 16-word cache refill bursts, holding refills back while they would read stale data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  refill_req,
  input  logic [ADDR_WIDTH-1:0] refill_addr,
  output logic [WORD_WIDTH-1:0] refill_data,
  output logic                  refill_data_valid,
  output logic [3:0]            refill_word_idx,
  output logic                  refill_done,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wbuf_empty,
  output logic [ADDR_WIDTH-1:0] memory_addr,
  output logic                  memory_write_en,
  output logic [WORD_WIDTH-1:0] memory_write_data,
  output logic                  memory_read_addr_valid,
  input  logic                  memory_read_ready,
  input  logic                  memory_read_valid,
  input  logic [WORD_WIDTH-1:0] memory_read_data
);

  localparam int unsigned PTR_W = $clog2(WBUF_DEPTH);

  arb_state_t            state;
  logic [ADDR_WIDTH-5:0] base;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      fill_cnt;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WORD_WIDTH-1:0] head_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PTR_W:0]        fifo_count;
  logic                  raw_hit;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^refill_addr[3:0];
  assign wr_ready         = !fifo_full;
  assign wbuf_empty       = (fifo_count == '0);

  write_buffer_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .DEPTH     (WBUF_DEPTH)
  ) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_valid && wr_ready),
    .push_addr(wr_addr),
    .push_data(wr_data),
    .pop      (state == DRAIN),
    .head_addr(head_addr),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .match_tag(refill_addr[ADDR_WIDTH-1:4]),
    .match_hit(raw_hit)
  );

  // NOTE: all state and registered outputs use <= so every branch sees the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      base                   <= '0;
      issue_cnt              <= '0;
      fill_cnt               <= '0;
      refill_data            <= '0;
      refill_data_valid      <= 1'b0;
      refill_word_idx        <= '0;
      refill_done            <= 1'b0;
      memory_addr            <= '0;
      memory_write_en        <= 1'b0;
      memory_write_data      <= '0;
      memory_read_addr_valid <= 1'b0;
    end else begin
      memory_write_en        <= 1'b0;
      memory_read_addr_valid <= 1'b0;
      refill_data_valid      <= 1'b0;
      refill_done            <= 1'b0;
      case (state)
        IDLE: begin
          // Refill wins unless an older buffered write targets the same block.
          if (refill_req && !raw_hit) begin
            state     <= REFILL;
            base      <= refill_addr[ADDR_WIDTH-1:4];
            issue_cnt <= '0;
            fill_cnt  <= '0;
          end else if (!fifo_empty) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          memory_addr       <= head_addr;
          memory_write_data <= head_data;
          memory_write_en   <= 1'b1;
          state             <= IDLE;
        end
        REFILL: begin
          if (fill_cnt == CNT_W'(BURST_LEN)) begin
            state     <= IDLE;
            issue_cnt <= '0;
            fill_cnt  <= '0;
          end else begin
            if ((issue_cnt < CNT_W'(BURST_LEN)) && memory_read_ready) begin
              memory_addr            <= {base, issue_cnt[3:0]};
              memory_read_addr_valid <= 1'b1;
              issue_cnt              <= issue_cnt + 1'b1;
            end
            if (memory_read_valid) begin
              refill_data       <= memory_read_data;
              refill_data_valid <= 1'b1;
              refill_word_idx   <= fill_cnt[3:0];
              fill_cnt          <= fill_cnt + 1'b1;
              if (fill_cnt == CNT_W'(BURST_LEN - 1)) refill_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-cycle in-order memory responder,
// an event monitor, and hand-derived expectations for each scenario.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refill_req = 1'b0;
  logic [31:0] refill_addr = '0;
  logic [31:0] refill_data;
  logic        refill_data_valid;
  logic [3:0]  refill_word_idx;
  logic        refill_done;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wbuf_empty;
  logic [31:0] memory_addr;
  logic        memory_write_en;
  logic [31:0] memory_write_data;
  logic        memory_read_addr_valid;
  logic        memory_read_ready = 1'b1;
  logic        memory_read_valid = 1'b0;
  logic [31:0] memory_read_data = '0;

  mem_port_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .refill_req            (refill_req),
    .refill_addr           (refill_addr),
    .refill_data           (refill_data),
    .refill_data_valid     (refill_data_valid),
    .refill_word_idx       (refill_word_idx),
    .refill_done           (refill_done),
    .wr_valid              (wr_valid),
    .wr_ready              (wr_ready),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .wbuf_empty            (wbuf_empty),
    .memory_addr           (memory_addr),
    .memory_write_en       (memory_write_en),
    .memory_write_data     (memory_write_data),
    .memory_read_addr_valid(memory_read_addr_valid),
    .memory_read_ready     (memory_read_ready),
    .memory_read_valid     (memory_read_valid),
    .memory_read_data      (memory_read_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: returns each issued read two cycles later, in order.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } rq_t;
  rq_t         rq[$];
  logic [31:0] cyc = '0;
  bit          mem_hold = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (memory_read_addr_valid) rq.push_back('{addr: memory_addr, due: cyc + 2});
    memory_read_valid = 1'b0;
    memory_read_data  = '0;
    if (!mem_hold && rq.size() > 0 && rq[0].due <= cyc) begin
      memory_read_valid = 1'b1;
      memory_read_data  = 32'hD000_0000 | rq[0].addr;
      void'(rq.pop_front());
    end
  end

  // Monitor
  localparam logic [1:0] EV_W = 2'd0, EV_R = 2'd1, EV_D = 2'd2;
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
  } ev_t;
  ev_t         ev_log[$];
  logic [63:0] wr_log[$];
  logic [31:0] rd_log[$];
  logic [35:0] dv_log[$];
  int          done_cnt = 0;
  int          both_cnt = 0;
  int          done_idx = -1;

  always @(negedge clk) begin
    if (memory_write_en) begin
      wr_log.push_back({memory_addr, memory_write_data});
      ev_log.push_back({EV_W, memory_addr});
    end
    if (memory_read_addr_valid) begin
      rd_log.push_back(memory_addr);
      ev_log.push_back({EV_R, memory_addr});
    end
    if (memory_write_en && memory_read_addr_valid) both_cnt++;
    if (refill_data_valid) dv_log.push_back({refill_word_idx, refill_data});
    if (refill_done) begin
      done_cnt++;
      done_idx = refill_data_valid ? int'(refill_word_idx) : -1;
      ev_log.push_back({EV_D, 32'h0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ev_log.delete();
    wr_log.delete();
    rd_log.delete();
    dv_log.delete();
    done_cnt = 0;
    both_cnt = 0;
    done_idx = -1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bit acc = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = wr_ready;
      tick();
    end
    wr_valid = 1'b0;
    check("write_accept_timeout", acc, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check("refill_done_timeout", done_cnt > 0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_wr_ready"}, wr_ready, 1);
    check({pfx, "_wbuf_empty"}, wbuf_empty, 1);
    check({pfx, "_mem_we"}, memory_write_en, 0);
    check({pfx, "_mem_rav"}, memory_read_addr_valid, 0);
    check({pfx, "_mem_addr"}, memory_addr, 0);
    check({pfx, "_mem_wdata"}, memory_write_data, 0);
    check({pfx, "_rf_valid"}, refill_data_valid, 0);
    check({pfx, "_rf_done"}, refill_done, 0);
    check({pfx, "_rf_data"}, refill_data, 0);
    check({pfx, "_rf_idx"}, refill_word_idx, 0);
  endtask

  initial begin
    int  acc;
    bit  a;
    int  p_w205, p_r, p_d, p_w900;

    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // Single write drains straight to memory
    clear_logs();
    do_write(32'h100, 32'hAAAA_0001);
    for (int i = 0; i < 20 && !(wbuf_empty && wr_log.size() > 0); i++) tick();
    repeat (3) tick();
    check("t1_write_cycles", wr_log.size(), 1);
    if (wr_log.size() > 0) check("t1_write", wr_log[0], {32'h100, 32'hAAAA_0001});
    check("t1_wbuf_empty", wbuf_empty, 1);

    // Full burst; low address bits ignored, request dropped mid-burst
    clear_logs();
    refill_req  = 1'b1;
    refill_addr = 32'h47;
    repeat (3) tick();
    refill_req = 1'b0;
    wait_done(200);
    repeat (4) tick();
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_with_idx15", done_idx, 15);
    check("t2_issue_cnt", rd_log.size(), 16);
    for (int i = 0; i < rd_log.size(); i++)
      check($sformatf("t2_issue_%0d", i), rd_log[i], 32'h40 + i);
    check("t2_data_cnt", dv_log.size(), 16);
    for (int i = 0; i < dv_log.size(); i++)
      check($sformatf("t2_data_%0d", i), dv_log[i], {4'(i), 32'hD000_0040 + i});
    check("t2_we_and_rav", both_cnt, 0);

    // RAW hazard: matching write drains first, unrelated write waits
    clear_logs();
    wr_valid = 1'b1; wr_addr = 32'h205; wr_data = 32'h1111_0205;
    tick();
    wr_addr = 32'h900; wr_data = 32'h2222_0900;
    refill_req = 1'b1; refill_addr = 32'h200;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 50 && rd_log.size() == 0; i++) tick();
    refill_req = 1'b0;
    wait_done(200);
    for (int i = 0; i < 50 && !(wbuf_empty && wr_log.size() >= 2); i++) tick();
    repeat (3) tick();
    p_w205 = -1; p_r = -1; p_d = -1; p_w900 = -1;
    foreach (ev_log[i]) begin
      if (ev_log[i].kind == EV_W && ev_log[i].addr == 32'h205 && p_w205 < 0) p_w205 = i;
      if (ev_log[i].kind == EV_R && p_r < 0) p_r = i;
      if (ev_log[i].kind == EV_D && p_d < 0) p_d = i;
      if (ev_log[i].kind == EV_W && ev_log[i].addr == 32'h900 && p_w900 < 0) p_w900 = i;
    end
    check("t3_first_read_addr", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, 32'h200);
    check("t3_w205_before_read", (p_w205 >= 0) && (p_w205 < p_r), 1);
    check("t3_w900_after_done", (p_d >= 0) && (p_w900 > p_d), 1);
    check("t3_write_cnt", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("t3_write0", wr_log[0], {32'h205, 32'h1111_0205});
      check("t3_write1", wr_log[1], {32'h900, 32'h2222_0900});
    end
    check("t3_we_and_rav", both_cnt, 0);

    // Buffer fills during a stalled refill; 5th write waits for draining
    clear_logs();
    mem_hold = 1'b1;
    refill_req = 1'b1; refill_addr = 32'h300;
    for (int i = 0; i < 20 && rd_log.size() == 0; i++) tick();
    refill_req = 1'b0;
    acc = 0;
    wr_valid = 1'b1; wr_addr = 32'h500; wr_data = 32'hBEEF_0000;
    for (int i = 0; i < 10; i++) begin
      a = wr_ready;
      tick();
      if (a) begin
        acc++;
        wr_addr = 32'h500 + acc;
        wr_data = 32'hBEEF_0000 + acc;
      end
    end
    check("t4_accepts_while_full", acc, 4);
    check("t4_wr_ready_full", wr_ready, 0);
    check("t4_wbuf_empty_full", wbuf_empty, 0);
    mem_hold = 1'b0;
    for (int i = 0; i < 200 && acc < 5; i++) begin
      a = wr_ready;
      tick();
      if (a) acc++;
    end
    wr_valid = 1'b0;
    check("t4_fifth_accepted", acc, 5);
    check("t4_done_before_fifth", done_cnt, 1);
    check("t4_drained_before_fifth", wr_log.size(), 1);
    for (int i = 0; i < 100 && !(wbuf_empty && wr_log.size() >= 5); i++) tick();
    check("t4_write_cnt", wr_log.size(), 5);
    for (int i = 0; i < wr_log.size(); i++)
      check($sformatf("t4_write_%0d", i), wr_log[i], {32'h500 + i, 32'hBEEF_0000 + i});

    // Reset mid-burst after the 7th returned word
    clear_logs();
    refill_req = 1'b1; refill_addr = 32'h8C;
    for (int i = 0; i < 200 && dv_log.size() < 7; i++) begin
      @(negedge clk);
      #1;
    end
    check("t5_seven_words", dv_log.size(), 7);
    rst = 1'b0;
    refill_req = 1'b0;
    #1;
    check_reset_outputs("t5");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) tick();
    check("t5_no_late_valid", dv_log.size(), 7);
    check("t5_no_done", done_cnt, 0);
    check("t5_no_read_issue", rd_log.size() <= 16, 1);
    check("t5_idle_wr_ready", wr_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; WORD_WIDTH, default 32, data word width; WBUF_DEPTH, default 4, write-buffer entries (power of 2); BURST_LEN, default 16, words per refill.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- refill_req  in  1  level; refill of one BURST_LEN-word block requested.
- refill_addr  in  ADDR_WIDTH  word address of block base; low 4 bits ignored.
- refill_data  out  WORD_WIDTH  returned word.
- refill_data_valid  out  1  refill_data valid this cycle.
- refill_word_idx  out  4  index 0..15 of refill_data.
- refill_done  out  1  one-cycle pulse after the last word.
- wr_valid  in  1  write-through request.
- wr_ready  out  1  write accepted when wr_valid and wr_ready.
- wr_addr  in  ADDR_WIDTH  word address.
- wr_data  in  WORD_WIDTH  write data.
- wbuf_empty  out  1  write buffer empty.
- memory_addr  out  ADDR_WIDTH  main-memory word address.
- memory_write_en  out  1  one-cycle write strobe.
- memory_write_data  out  WORD_WIDTH  write data.
- memory_read_addr_valid  out  1  read address issue strobe.
- memory_read_ready  in  1  memory accepts a read address this cycle.
- memory_read_valid  in  1  memory_read_data valid; returns arrive in issue order.
- memory_read_data  in  WORD_WIDTH  read data.

Function
REQ-003 SHALL buffer writes in a WBUF_DEPTH FIFO; wr_ready = not full (combinational from count); push and pop in the same cycle SHALL leave the count unchanged, including when full.
REQ-004 SHALL use a three-state FSM: IDLE, DRAIN, REFILL.
REQ-005 IDLE: if refill_req and no buffered entry matches refill_addr[ADDR_WIDTH-1:4] (RAW hazard) -> REFILL; else if FIFO non-empty -> DRAIN; else stay.
REQ-006 DRAIN: pop one entry per cycle and drive memory_addr/memory_write_data with memory_write_en=1 for exactly one registered cycle; return to IDLE after each pop, so refill is re-evaluated between writes.
REQ-007 A refill blocked by a hazard SHALL wait while matching entries drain, then enter REFILL without draining the non-matching entries.
REQ-008 REFILL: on each cycle with issue_cnt < BURST_LEN and memory_read_ready, register memory_addr = {refill_addr[ADDR_WIDTH-1:4], issue_cnt[3:0]} and memory_read_addr_valid=1, then increment issue_cnt; base latched on entry.
REQ-009 Each memory_read_valid in REFILL SHALL produce refill_data_valid=1 the next cycle with refill_word_idx = fill_cnt, then fill_cnt increments.
REQ-010 refill_done SHALL pulse in the same cycle as the 16th refill_data_valid; the FSM SHALL return to IDLE the following cycle, clearing both counters.
REQ-011 refill_req deassertion mid-burst SHALL be ignored; the burst completes.
REQ-012 Writes SHALL still be accepted into the FIFO during REFILL but not issued until IDLE.
REQ-013 memory_read_valid outside REFILL SHALL be ignored.
REQ-014 memory_write_en and memory_read_addr_valid SHALL never be asserted in the same cycle.
REQ-015 Counter widths: issue_cnt and fill_cnt 5 bits (0..16), FIFO pointers log2(WBUF_DEPTH) bits with wrap-around, count log2(WBUF_DEPTH)+1 bits.

Reset
REQ-016 On rst low, SHALL immediately enter IDLE, empty the FIFO, and clear counters; all outputs 0 except wr_ready=1 and wbuf_empty=1.
REQ-017 Reset mid-burst SHALL abandon the burst with no refill_done; later stray memory_read_valid is ignored per REQ-013.

Structure
REQ-018 A shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE, DRAIN, REFILL) and the BURST_LEN and WBUF_DEPTH defaults.
REQ-019 The FIFO SHALL be one sub-module, write_buffer_fifo, exposing push, pop, full, empty, count and a hazard-match input/output.

Verification
REQ-020 Write 0x100/0xAAAA0001 with memory idle -> memory_write_en one cycle, memory_addr=0x100, data=0xAAAA0001; wbuf_empty returns to 1.
REQ-021 Refill 0x40, memory_read_ready=1, 2-cycle read latency -> addresses 0x40..0x4F issued in order, 16 refill_data_valid with idx 0..15, one refill_done.
REQ-022 Buffer writes to 0x205 and 0x900, then refill 0x200 -> 0x205 written before the first read issue; 0x900 written only after refill_done.
REQ-023 Five back-to-back writes with memory held in REFILL -> wr_ready drops after 4 accepts; the 5th is accepted once draining starts.
REQ-024 Assert rst after the 7th read return -> all outputs at reset values, no refill_done, late memory_read_valid produces no refill_data_valid.
